// File: rtl/gf_2to8_multiplicative_inversion_pipe.sv
// GF(2^8) multiplicative inversion via the GF((2^4)^2) composite field.
// Three registered stages carry h, l and the norm d or its inverse. Valid and
// tag ride alongside in a matching 3-deep shift register.

// GF(2^4) multiplier, field polynomial x^4+x+1.
module gf_2to4_multiplier (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [3:0] o_product
);
    logic [6:0] prod;

    // Carry-less multiply, then fold bits 6..4 back using x^4 = x+1.
    always_comb begin
        prod = '0;
        for (int i = 0; i < 4; i++) begin
            if (i_b[i]) prod = prod ^ ({3'b000, i_a} << i);
        end
        for (int k = 6; k >= 4; k--) begin
            if (prod[k]) prod = prod ^ (7'b0010011 << (k - 4));
        end
        o_product = prod[3:0];
    end
endmodule

// GF(2^4) inversion, x^4+x+1; 0 maps to 0.
module gf_2to4_inversion (
    input  logic [3:0] i_data,
    output logic [3:0] o_data
);
    // Table lookup: inverse of alpha^k is alpha^(15-k).
    always_comb begin
        case (i_data)
            4'h1:    o_data = 4'h1;
            4'h2:    o_data = 4'h9;
            4'h3:    o_data = 4'he;
            4'h4:    o_data = 4'hd;
            4'h5:    o_data = 4'hb;
            4'h6:    o_data = 4'h7;
            4'h7:    o_data = 4'h6;
            4'h8:    o_data = 4'hf;
            4'h9:    o_data = 4'h2;
            4'ha:    o_data = 4'hc;
            4'hb:    o_data = 4'h5;
            4'hc:    o_data = 4'ha;
            4'hd:    o_data = 4'h4;
            4'he:    o_data = 4'h3;
            4'hf:    o_data = 4'h8;
            default: o_data = 4'h0;
        endcase
    end
endmodule

module gf_2to8_multiplicative_inversion_pipe #(
    parameter  int NB_BYTE = 8,
    parameter  int N_BYTES = 16,
    parameter  int NB_TAG  = 4,
    localparam int NB_DATA = N_BYTES * NB_BYTE
) (
    input  logic               i_clock,
    input  logic               i_reset,
    output logic [NB_DATA-1:0] o_data,
    output logic [NB_TAG-1:0]  o_tag,
    output logic               o_valid,
    input  logic [NB_DATA-1:0] i_data,
    input  logic [NB_TAG-1:0]  i_tag,
    input  logic               i_valid,
    input  logic               i_enable
);
    // Squaring in GF(2^4): x^4 = x+1, x^6 = x^3+x^2.
    function automatic logic [3:0] gf4_square(input logic [3:0] a);
        return {a[3], a[3] ^ a[1], a[2], a[2] ^ a[0]};
    endfunction

    // Multiply by lambda = x^3+x^2.
    function automatic logic [3:0] gf4_mul_lambda(input logic [3:0] a);
        return {a[0] ^ a[1] ^ a[3], a[0] ^ a[2], a[1] ^ a[3], a[1] ^ a[2]};
    endfunction

    // delta: AES polynomial basis -> {h,l}; x maps to the root 0x21.
    function automatic logic [7:0] iso_map(input logic [7:0] q);
        return {q[5] ^ q[7],
                q[2] ^ q[3] ^ q[5] ^ q[7],
                q[1] ^ q[4] ^ q[6] ^ q[7],
                q[4] ^ q[5] ^ q[6],
                q[3] ^ q[5] ^ q[6],
                q[2] ^ q[3] ^ q[4] ^ q[6],
                q[3] ^ q[5] ^ q[7],
                q[0] ^ q[1]};
    endfunction

    // delta^-1: {h,l} -> AES polynomial basis.
    function automatic logic [7:0] iso_map_inv(input logic [7:0] t);
        return {t[2] ^ t[4] ^ t[6],
                t[1] ^ t[2] ^ t[3] ^ t[4] ^ t[6],
                t[2] ^ t[4] ^ t[6] ^ t[7],
                t[1] ^ t[3] ^ t[4] ^ t[7],
                t[1] ^ t[7],
                t[1] ^ t[6],
                t[4] ^ t[5] ^ t[7],
                t[0] ^ t[4] ^ t[5] ^ t[7]};
    endfunction

    logic [N_BYTES-1:0][3:0] s1_h_d, s1_l_d, s1_norm_d;
    logic [N_BYTES-1:0][3:0] s1_h, s1_l, s1_norm;
    logic [N_BYTES-1:0][3:0] s2_norm_inv_d;
    logic [N_BYTES-1:0][3:0] s2_h, s2_l, s2_norm_inv;
    logic [N_BYTES-1:0][7:0] s3_data_d, s3_data;
    logic [2:0]              valid_sr;
    logic [2:0][NB_TAG-1:0]  tag_sr;

    for (genvar k = 0; k < N_BYTES; k++) begin : g_lane
        logic [7:0] iso;
        logic [3:0] hl_l;
        logic [3:0] h_out;
        logic [3:0] l_out;

        assign iso       = iso_map(i_data[k*NB_BYTE +: NB_BYTE]);
        assign s1_h_d[k] = iso[7:4];
        assign s1_l_d[k] = iso[3:0];

        // Norm d = lambda*h^2 + (h+l)*l.
        gf_2to4_multiplier u_mul_norm (
            .i_a       (iso[7:4] ^ iso[3:0]),
            .i_b       (iso[3:0]),
            .o_product (hl_l)
        );
        assign s1_norm_d[k] = gf4_mul_lambda(gf4_square(iso[7:4])) ^ hl_l;

        gf_2to4_inversion u_inv (
            .i_data (s1_norm[k]),
            .o_data (s2_norm_inv_d[k])
        );

        // Inverse = (h*y + (h+l)) / d.
        gf_2to4_multiplier u_mul_h (
            .i_a       (s2_h[k]),
            .i_b       (s2_norm_inv[k]),
            .o_product (h_out)
        );
        gf_2to4_multiplier u_mul_l (
            .i_a       (s2_h[k] ^ s2_l[k]),
            .i_b       (s2_norm_inv[k]),
            .o_product (l_out)
        );
        assign s3_data_d[k] = iso_map_inv({h_out, l_out});
    end

    // Data pipeline: reset clears every stage, otherwise advance on enable.
    // NOTE: data registers are reset too so the output bus reads zero after reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            s1_h        <= '0;
            s1_l        <= '0;
            s1_norm     <= '0;
            s2_h        <= '0;
            s2_l        <= '0;
            s2_norm_inv <= '0;
            s3_data     <= '0;
        end else if (i_enable) begin
            // NOTE: non-blocking assignments so every stage samples the old value of the one before it.
            s1_h        <= s1_h_d;
            s1_l        <= s1_l_d;
            s1_norm     <= s1_norm_d;
            s2_h        <= s1_h;
            s2_l        <= s1_l;
            s2_norm_inv <= s2_norm_inv_d;
            s3_data     <= s3_data_d;
        end
    end

    // Valid and tag shift in lockstep with the data stages.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            valid_sr <= '0;
            tag_sr   <= '0;
        end else if (i_enable) begin
            valid_sr <= {valid_sr[1:0], i_valid};
            tag_sr   <= {tag_sr[1:0], i_tag};
        end
    end

    assign o_data  = s3_data;
    assign o_valid = valid_sr[2];
    assign o_tag   = tag_sr[2];
endmodule
